// File: rtl/branch_compare_pipe.sv
// Pipelined branch/set condition evaluator with mispredict detection.
// Ports: valid/ready in (A, B, CompareControl, PredTaken, TagIn),
//   valid/ready out (CompareResult, Mispredict, IllegalOp, TagOut),
//   Flush kills in-flight ops, saturating Branch/MispredictCount.
`timescale 1ns/1ps
module branch_compare_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       CompareControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             PredTaken,
  input  logic [TAG_W-1:0] TagIn,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             CompareResult,
  output logic             Mispredict,
  output logic             IllegalOp,
  output logic [TAG_W-1:0] TagOut,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int L = STAGES - 1;

  typedef struct packed {
    logic             result;
    logic             pred;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic a_neg, a_zero, eq, lt_s, lt_u;
  logic cmp_res, cmp_ill;

  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);
  assign eq     = (A == B);
  assign lt_s   = $signed(A) < $signed(B);
  assign lt_u   = A < B;

  always_comb begin
    cmp_res = 1'b0;
    cmp_ill = 1'b0;
    unique case (CompareControl)
      4'd0:    cmp_res = ~a_neg & ~a_zero;
      4'd1:    cmp_res = a_neg;
      4'd2:    cmp_res = ~a_neg;
      4'd3:    cmp_res = a_neg | a_zero;
      4'd4:    cmp_res = eq;
      4'd5:    cmp_res = ~eq;
      4'd6:    cmp_res = lt_s;
      4'd7:    cmp_res = ~lt_s;
      4'd8:    cmp_res = lt_u;
      4'd9:    cmp_res = ~lt_u;
      default: cmp_ill = 1'b1;
    endcase
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  stage_t            pl [STAGES];
  logic              accept;
  logic              retire;
  logic [CNT_W-1:0]  bc, mc;

  // A stage can move iff some stage at or after it is empty,
  // or the consumer drains the tail this cycle.
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    assign adv[i] = ~(&v[STAGES-1:i]) | OutReady;
  end

  assign InReady = adv[0] & ~Flush;
  assign accept  = InValid & InReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) pl[i] <= '0;
    end else if (Flush) begin
      v <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= accept;
        if (accept)
          pl[0] <= {cmp_res, PredTaken, cmp_ill, TagIn};
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) pl[i] <= pl[i-1];
        end
      end
    end
  end

  assign OutValid      = v[L];
  assign CompareResult = pl[L].result;
  assign Mispredict    = pl[L].result ^ pl[L].pred;
  assign IllegalOp     = pl[L].illegal;
  assign TagOut        = pl[L].tag;

  assign retire = v[L] & OutReady & ~Flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bc <= '0;
      mc <= '0;
    end else if (retire) begin
      if (~&bc) bc <= bc + 1'b1;
      if (Mispredict && ~&mc) mc <= mc + 1'b1;
    end
  end

  assign BranchCount     = bc;
  assign MispredictCount = mc;

endmodule
